divider: RTL and testbench

Iterative radix-2 integer divider for the RV32M execute stage, the division counterpart to the pipelined multiplier. It accepts one DIV/DIVU/REM/REMU operation per start pulse, produces one quotient bit per cycle, and signals completion with a one-cycle `done` pulse. The hazard unit stalls the pipeline while `busy` is high.

---
 rtl/divider_if.sv | 15 +
 rtl/divider.sv | 157 +++++++++++++++
 tb/tb_divider.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Operand/result handshake bundle between the execute stage and the RV32M divider.
interface divider_if #(
    parameter int WIDTH = 32
);
    logic             ce;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (output ce, funct3, a, b, input result, busy, done);
    modport slave  (input ce, funct3, a, b, output result, busy, done);
endinterface

// File: rtl/divider.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU: done one cycle after E33 (E1 for boundary
// operands when DIVIDER_EARLY_OUT_EN is defined); ce is only sampled in IDLE, busy stalls the pipe.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_FINISH} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_busy;
    logic [2:0]       r_funct3;
    logic             r_neg_a;
    logic             r_neg_b;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_abs_b;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_done;

    logic             w_signed;
    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_early;
    logic [WIDTH+1:0] w_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_res;

    assign w_signed = bus.funct3[2] & ~bus.funct3[0];
    assign w_neg_a  = w_signed & bus.a[WIDTH-1];
    assign w_neg_b  = w_signed & bus.b[WIDTH-1];
    assign w_b_zero = (bus.b == '0);
    assign w_abs_a  = w_neg_a ? -bus.a : bus.a;
    assign w_abs_b  = w_neg_b ? -bus.b : bus.b;

`ifdef DIVIDER_EARLY_OUT_EN
    assign w_early = bus.funct3[2] &
                     (w_b_zero | (w_signed & (bus.a == MIN_NEG) & (bus.b == '1)));
`else
    assign w_early = 1'b0;
`endif

    // One restoring step: bring in the next dividend bit, keep the difference if it fits.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {2'b00, r_abs_b});
    assign w_sub   = (WIDTH+1)'(w_shift - {2'b00, r_abs_b});

    // Divide-by-zero leaves quotient all-ones and remainder |a|, so b=0 must not negate the quotient.
    assign w_q_fix = ((r_neg_a ^ r_neg_b) & ~r_b_zero) ? -r_quo : r_quo;
    assign w_r_fix = r_neg_a ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_comb begin
        w_res = '0;
        case (r_funct3)
            3'b100, 3'b101: w_res = w_q_fix;
            3'b110, 3'b111: w_res = w_r_fix;
            default:        w_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ce) begin
                    w_state_nxt = w_early ? S_FINISH : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_funct3 <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_b_zero <= 1'b0;
            r_quo    <= '0;
            r_abs_b  <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ce) begin
                        r_funct3 <= bus.funct3;
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_b_zero <= w_b_zero;
                        r_abs_b  <= w_abs_b;
                        r_cnt    <= '0;
                        // Early-out stages exactly what the full iteration would have produced.
                        if (w_early) begin
                            r_quo <= w_b_zero ? '1 : MIN_NEG;
                            r_rem <= w_b_zero ? {1'b0, w_abs_a} : '0;
                        end else begin
                            r_quo <= w_abs_a;
                            r_rem <= '0;
                        end
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_ge ? w_sub : w_shift[WIDTH:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FINISH: begin
                    r_result <= w_res;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.busy   = w_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_divider.sv
// Randomised bench for divider against an arithmetic reference model, plus literal boundary cases.
module tb_divider;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    divider_if #(.WIDTH(32)) bus ();
    divider #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef DIVIDER_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic               ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            3'b100:  return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
            3'b101:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110:  return (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
            3'b111:  return (y == 0) ? x : x % y;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        bit boundary;
        boundary = f[2] && ((y == 0) ||
                   (!f[0] && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)));
        return (EARLY && boundary) ? 1 : 33;
    endfunction

    // Reference timeline: edges remaining until done, and the result that done will carry.
    int          m_cnt = 0;
    logic [31:0] m_pend = '0;
    logic        exp_done = 1'b0;
    logic [31:0] exp_result = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt      <= 0;
            exp_done   <= 1'b0;
            exp_result <= '0;
        end else if (m_cnt == 0) begin
            exp_done <= 1'b0;
            if (bus.ce) begin
                m_cnt  <= lat_of(bus.funct3, bus.a, bus.b);
                m_pend <= ref_div(bus.funct3, bus.a, bus.b);
            end
        end else begin
            m_cnt    <= m_cnt - 1;
            exp_done <= (m_cnt == 1);
            if (m_cnt == 1) exp_result <= m_pend;
        end
    end

    always @(negedge clk) begin
        check("done", 32'(bus.done), 32'(exp_done));
        check("busy", 32'(bus.busy), 32'(m_cnt != 0));
        check("result", bus.result, exp_result);
    end

    // Issues one op at a negedge and returns at the negedge of its done cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] lit, input bit use_lit, input bit inject);
        int n;
        bus.ce = 1'b1; bus.funct3 = f; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.ce = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.funct3 = 3'($urandom);
        n = 1;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
            if (inject && n == 5) begin
                bus.ce = 1'b1; bus.funct3 = 3'b101; bus.a = $urandom; bus.b = $urandom_range(1, 9);
            end else begin
                bus.ce = 1'b0;
            end
        end
        if (!bus.done) begin
            checks++; errors++;
            $display("FAIL timeout: no done within %0d cycles (op %b a=0x%08h b=0x%08h)", n, f, x, y);
        end else begin
            check("latency", 32'(n), 32'(lat_of(f, x, y) + 1));
            if (use_lit) check("literal", bus.result, lit);
        end
    endtask

    logic [2:0]  d_f   [12] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110,
                                3'b101, 3'b111, 3'b100, 3'b110, 3'b011, 3'b101};
    logic [31:0] d_a   [12] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5,
                                32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd100, 32'd100};
    logic [31:0] d_b   [12] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd0, 32'd0, 32'd0, 32'd0, 32'd7, 32'd7};
    logic [31:0] d_exp [12] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5,
                                32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd0, 32'd14};

    initial begin
        bus.ce = 1'b0; bus.funct3 = '0; bus.a = '0; bus.b = '0;
        #2 reset = 1'b1;
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // Directed ops run back-to-back: each one is issued in the previous op's done cycle.
        for (int i = 0; i < 12; i++) begin
            run_op(d_f[i], d_a[i], d_b[i], d_exp[i], 1'b1, i == 11);
        end

        // Abort at iteration 10; result had been 14 beforehand.
        bus.ce = 1'b1; bus.funct3 = 3'b100; bus.a = 32'd1000; bus.b = 32'd3;
        @(negedge clk);
        bus.ce = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (40) @(negedge clk);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 1'b1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f;
            logic [31:0] x;
            logic [31:0] y;
            int          sel;
            f   = ($urandom_range(0, 7) != 0) ? {1'b1, 2'($urandom)} : 3'($urandom);
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = 32'd0;
            else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            else if (sel == 2) y = $urandom_range(1, 20);
            else if (sel == 3) y = -$urandom_range(1, 20);
            run_op(f, x, y, 32'h0, 1'b0, ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
